player_ctrl: RTL

PLAYER_CTRL -- requirements
Module: player_ctrl

---
 rtl/player_pkg.sv | 18 +
 rtl/player_ctrl_one_pulse.sv | 25 ++
 rtl/player_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/player_pkg.sv
// Shared constants for the song player controller: default sizing and FSM state encodings.
package player_pkg;

  localparam int NUM_SONGS_DEF = 4;
  localparam int TICK_DIV_DEF  = 65536;

  localparam logic [2:0] ST_INIT         = 3'd0;
  localparam logic [2:0] ST_PAUSED       = 3'd1;
  localparam logic [2:0] ST_PLAYING      = 3'd2;
  localparam logic [2:0] ST_NEXT_PAUSED  = 3'd3;
  localparam logic [2:0] ST_NEXT_PLAYING = 3'd4;

  // States in which the song reader is held at its first note.
  function automatic logic holds_reader(input logic [2:0] st);
    return (st == ST_INIT) || (st == ST_NEXT_PAUSED) || (st == ST_NEXT_PLAYING);
  endfunction

endpackage

// File: rtl/player_ctrl_one_pulse.sv
// Rising-edge detector: one-cycle pulse per 0->1 transition of a synchronous button level.
module one_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic btn_q;
  logic btn_prev_q;

  // Two-stage history so the pulse comes from registers only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q      <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      btn_q      <= btn_i;
      btn_prev_q <= btn_q;
    end
  end

  assign pulse_o = btn_q & ~btn_prev_q;

endmodule

// File: rtl/player_ctrl.sv
// Song player controller: debounce tick generator plus play/pause/next FSM driving the note player.
module player_ctrl
  import player_pkg::*;
#(
  parameter int  NUM_SONGS = NUM_SONGS_DEF,
  parameter int  TICK_DIV  = TICK_DIV_DEF,
  localparam int SONG_W    = $clog2(NUM_SONGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_btn,
  input  logic              next_btn,
  input  logic              song_done,
  output logic              tick_en,
  output logic              play,
  output logic              player_reset,
  output logic [SONG_W-1:0] song
);

  localparam int                CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [SONG_W-1:0] SONG_MAX = SONG_W'(NUM_SONGS - 1);

  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              tick_en_q;
  logic [2:0]        state_q, state_d;
  logic [SONG_W-1:0] song_q,  song_d;
  logic              play_q;
  logic              player_reset_q;
  logic              play_press;
  logic              next_press;

  one_pulse u_play_pulse (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (play_btn),
    .pulse_o (play_press)
  );

  one_pulse u_next_pulse (
    .clk     (clk),
    .rst_n   (reset),
    .btn_i   (next_btn),
    .pulse_o (next_press)
  );

  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Priority next > song_done > play; losers are dropped, and NEXT_* ignores all events.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:         state_d = ST_PAUSED;
      ST_PAUSED: begin
        if (next_press) begin
          state_d = ST_NEXT_PAUSED;
        end else if (play_press) begin
          state_d = ST_PLAYING;
        end else begin
          state_d = ST_PAUSED;
        end
      end
      ST_PLAYING: begin
        if (next_press || song_done) begin
          state_d = ST_NEXT_PLAYING;
        end else if (play_press) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_PLAYING;
        end
      end
      ST_NEXT_PAUSED:  state_d = ST_PAUSED;
      ST_NEXT_PLAYING: state_d = ST_PLAYING;
      default:         state_d = ST_INIT;
    endcase
  end

  always_comb begin
    if ((state_q == ST_NEXT_PAUSED) || (state_q == ST_NEXT_PLAYING)) begin
      song_d = (song_q >= SONG_MAX) ? '0 : song_q + SONG_W'(1);
    end else begin
      song_d = song_q;
    end
  end

  // Outputs are registered from next-state so no input reaches them combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q          <= '0;
      tick_en_q      <= 1'b0;
      state_q        <= ST_INIT;
      song_q         <= '0;
      play_q         <= 1'b0;
      player_reset_q <= 1'b1;
    end else begin
      cnt_q          <= cnt_d;
      tick_en_q      <= (cnt_d == CNT_MAX);
      state_q        <= state_d;
      song_q         <= song_d;
      play_q         <= (state_d == ST_PLAYING);
      player_reset_q <= holds_reader(state_d);
    end
  end

  assign tick_en      = tick_en_q;
  assign play         = play_q;
  assign player_reset = player_reset_q;
  assign song         = song_q;

endmodule
